// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter letting fetch (m0) and LSU (m1) share one single-port RAM port.
// Latency: grant at the edge after valid, s_valid_o next cycle, m*_ready_o mirrors s_ready_i; 3 cycles/access min.
// Backpressure: requesters hold valid until their ready pulse; only one access is ever outstanding.
// Ports: clk/rst (sync, active-high); m0_*/m1_* requester valid/addr/wdata/we in, ready/rdata out;
//        s_* registered request toward RAM, s_ready_i/s_rdata_i completion from RAM.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_valid_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m0_we_i,
  output logic                    m0_ready_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_valid_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m1_we_i,
  output logic                    m1_ready_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    s_valid_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  output logic [DATA_WIDTH/8-1:0] s_we_o,
  input  logic                    s_ready_i,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t                state_q, state_d;
  // grant/last_grant encode the requester: 0 = m0, 1 = m1
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic                  win;
  logic                  s_valid_d;
  logic [ADDR_WIDTH-1:0] s_addr_d;
  logic [DATA_WIDTH-1:0] s_wdata_d;
  logic [BE_WIDTH-1:0]   s_we_d;
  logic                  busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      s_valid_o    <= 1'b0;
      s_addr_o     <= '0;
      s_wdata_o    <= '0;
      s_we_o       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      s_valid_o    <= s_valid_d;
      s_addr_o     <= s_addr_d;
      s_wdata_o    <= s_wdata_d;
      s_we_o       <= s_we_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s_valid_d    = 1'b0;
    s_addr_d     = s_addr_o;
    s_wdata_d    = s_wdata_o;
    s_we_d       = s_we_o;
    win          = 1'b0;

    case (state_q)
      IDLE: begin
        // Only IDLE grants, so a requester's valid still high in its own
        // completion cycle can never cause a second, stale grant.
        if (m0_valid_i || m1_valid_i) begin
          if (m0_valid_i && m1_valid_i) begin
            win = ~last_grant_q;
          end else begin
            win = m1_valid_i;
          end
          grant_d      = win;
          last_grant_d = win;
          s_valid_d    = 1'b1;
          s_addr_d     = win ? m1_addr_i  : m0_addr_i;
          s_wdata_d    = win ? m1_wdata_i : m0_wdata_i;
          s_we_d       = win ? m1_we_i    : m0_we_i;
          state_d      = ISSUE;
        end
      end
      // A zero-latency RAM can complete in the same cycle as the request pulse.
      ISSUE:   state_d = s_ready_i ? IDLE : WAIT;
      WAIT:    if (s_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Completions are forwarded only while an access is in flight; a ready
  // seen in IDLE (spurious, or left over from before a reset) is dropped.
  assign busy       = (state_q != IDLE);
  assign m0_ready_o = busy && s_ready_i && !grant_q;
  assign m1_ready_o = busy && s_ready_i &&  grant_q;
  assign m0_rdata_o = s_rdata_i;
  assign m1_rdata_o = s_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed bench for mem_arbiter against a small word RAM model with programmable latency.
// Latency: RAM answers ram_lat cycles after the s_valid_o cycle with the old word, then applies byte writes.
// Backpressure: bench requesters hold valid until their ready pulse, then drop it.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_we, m1_we;
  logic        m0_ready_o, m1_ready_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_valid_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_we_o;
  logic        s_ready_i;
  logic [31:0] s_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;
  int ram_lat  = 1;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_valid_i(m0_valid),
    .m0_addr_i (m0_addr),
    .m0_wdata_i(m0_wdata),
    .m0_we_i   (m0_we),
    .m0_ready_o(m0_ready_o),
    .m0_rdata_o(m0_rdata_o),
    .m1_valid_i(m1_valid),
    .m1_addr_i (m1_addr),
    .m1_wdata_i(m1_wdata),
    .m1_we_i   (m1_we),
    .m1_ready_o(m1_ready_o),
    .m1_rdata_o(m1_rdata_o),
    .s_valid_o (s_valid_o),
    .s_addr_o  (s_addr_o),
    .s_wdata_o (s_wdata_o),
    .s_we_o    (s_we_o),
    .s_ready_i (s_ready_i),
    .s_rdata_i (s_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: the only writer of mem, s_ready_i and s_rdata_i.
  logic [31:0] mem [0:63];
  bit          mem_init = 0;
  int          cnt = 0;
  logic [5:0]  req_idx;
  logic [31:0] req_wdata;
  logic [3:0]  req_we;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h0BAD_F00D;
      4:       return 32'hDEAD_BEEF;
      8:       return 32'h2020_2020;
      9:       return 32'h2424_2424;
      16:      return 32'h55AA_55AA;
      17:      return 32'h1357_2468;
      default: return 32'h0000_0000;
    endcase
  endfunction

  initial begin
    s_ready_i = 1'b0;
    s_rdata_i = '0;
  end

  always @(posedge clk) begin
    #1;
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] = init_word(i);
      mem_init = 1;
    end
    s_ready_i = 1'b0;
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        s_ready_i = 1'b1;
        s_rdata_i = mem[req_idx];
        for (int b = 0; b < 4; b++)
          if (req_we[b]) mem[req_idx][8*b +: 8] = req_wdata[8*b +: 8];
      end
    end
    if (s_valid_o === 1'b1) begin
      cnt       = ram_lat;
      req_idx   = s_addr_o[7:2];
      req_wdata = s_wdata_o;
      req_we    = s_we_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one access after an idle cycle; returns rdata and negedges from drive to ready.
  task automatic do_access(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] we, output logic [31:0] rdata,
                           output int cycles, output bit ok);
    ok = 0; cycles = 0; rdata = '0;
    @(negedge clk);
    if (port == 1'b0) begin
      m0_valid = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_we = we;
    end else begin
      m1_valid = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_we = we;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((port == 1'b0 && m0_ready_o === 1'b1) || (port == 1'b1 && m1_ready_o === 1'b1)) begin
        rdata  = port ? m1_rdata_o : m0_rdata_o;
        cycles = i;
        ok     = 1;
        break;
      end
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    m0_valid = 1'b1; m0_addr = 32'h8;
    @(negedge clk);
    n_checks++; if (s_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_s_valid: got %b want 0", s_valid_o); end
    n_checks++; if (s_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_s_addr: got %h want 0", s_addr_o); end
    n_checks++; if (s_wdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_s_wdata: got %h want 0", s_wdata_o); end
    n_checks++; if (s_we_o !== 4'h0) begin n_fail++; $display("FAIL reset_s_we: got %h want 0", s_we_o); end
    n_checks++; if ({m0_ready_o, m1_ready_o} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b%b want 00", m0_ready_o, m1_ready_o); end
    rst = 1'b0; m0_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (s_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_wins_over_valid: s_valid got %b want 0", s_valid_o); end
  endtask

  task automatic test_single_fetch;
    m0_valid = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h0; m0_we = 4'h0;
    @(negedge clk);
    n_checks++; if (s_valid_o !== 1'b1) begin n_fail++; $display("FAIL fetch_s_valid: got %b want 1", s_valid_o); end
    n_checks++; if (s_addr_o !== 32'h10) begin n_fail++; $display("FAIL fetch_s_addr: got %h want 00000010", s_addr_o); end
    n_checks++; if (s_we_o !== 4'h0) begin n_fail++; $display("FAIL fetch_s_we: got %h want 0", s_we_o); end
    n_checks++; if (m0_ready_o !== 1'b0) begin n_fail++; $display("FAIL fetch_early_ready: got %b want 0", m0_ready_o); end
    @(negedge clk);
    n_checks++; if (m0_ready_o !== 1'b1) begin n_fail++; $display("FAIL fetch_ready: got %b want 1", m0_ready_o); end
    n_checks++; if (m0_rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fetch_rdata: got %h want deadbeef", m0_rdata_o); end
    n_checks++; if (m1_ready_o !== 1'b0) begin n_fail++; $display("FAIL fetch_m1_ready: got %b want 0", m1_ready_o); end
    n_checks++; if (s_valid_o !== 1'b0) begin n_fail++; $display("FAIL fetch_single_pulse: s_valid got %b want 0", s_valid_o); end
    m0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (s_valid_o !== 1'b0 || m0_ready_o !== 1'b0) begin n_fail++; $display("FAIL fetch_no_regrant: s_valid=%b ready=%b want 0 0", s_valid_o, m0_ready_o); end
    n_checks++; if (s_addr_o !== 32'h10) begin n_fail++; $display("FAIL fetch_addr_hold: got %h want 00000010", s_addr_o); end
  endtask

  task automatic test_simultaneous;
    logic [31:0] rd;
    int          cyc;
    bit          ok;
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h0; m0_wdata = 32'h0; m0_we = 4'h0;
    m1_valid = 1'b1; m1_addr = 32'h4; m1_wdata = 32'h1234_5678; m1_we = 4'hF;
    @(negedge clk);
    n_checks++; if (s_addr_o !== 32'h0 || s_we_o !== 4'h0) begin n_fail++; $display("FAIL tie_first_is_m0: addr=%h we=%h want 00000000 0", s_addr_o, s_we_o); end
    @(negedge clk);
    n_checks++; if ({m0_ready_o, m1_ready_o} !== 2'b10) begin n_fail++; $display("FAIL tie_m0_done: ready m0m1=%b%b want 10", m0_ready_o, m1_ready_o); end
    n_checks++; if (m0_rdata_o !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL tie_m0_rdata: got %h want 0badf00d", m0_rdata_o); end
    m0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (s_valid_o !== 1'b1 || s_addr_o !== 32'h4 || s_we_o !== 4'hF || s_wdata_o !== 32'h1234_5678) begin
      n_fail++; $display("FAIL tie_m1_issue: v=%b addr=%h we=%h wdata=%h want 1 00000004 f 12345678", s_valid_o, s_addr_o, s_we_o, s_wdata_o);
    end
    @(negedge clk);
    n_checks++; if ({m0_ready_o, m1_ready_o} !== 2'b01) begin n_fail++; $display("FAIL tie_m1_done: ready m0m1=%b%b want 01", m0_ready_o, m1_ready_o); end
    n_checks++; if (m1_rdata_o !== 32'h0) begin n_fail++; $display("FAIL tie_m1_old_data: got %h want 00000000", m1_rdata_o); end
    m1_valid = 1'b0;
    do_access(1'b0, 32'h4, 32'h0, 4'h0, rd, cyc, ok);
    n_checks++; if (!ok || rd !== 32'h1234_5678) begin n_fail++; $display("FAIL tie_readback: ok=%0d got %h want 12345678", ok, rd); end
    n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL tie_readback_latency: got %0d want 2", cyc); end
  endtask

  task automatic test_contention;
    int k;
    bit port;
    k = 0;
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h0; m0_we = 4'h0;
    m1_valid = 1'b1; m1_addr = 32'h24; m1_wdata = 32'h0; m1_we = 4'h0;
    for (int c = 1; c <= 40 && k < 6; c++) begin
      @(negedge clk);
      if (m0_ready_o === 1'b1 || m1_ready_o === 1'b1) begin
        port = (m1_ready_o === 1'b1);
        n_checks++; if (m0_ready_o === 1'b1 && m1_ready_o === 1'b1) begin n_fail++; $display("FAIL contend_both_ready: access %0d", k); end
        n_checks++; if (port !== k[0]) begin n_fail++; $display("FAIL contend_order: access %0d got m%0d want m%0d", k, port, k[0]); end
        n_checks++; if (c !== 2 + 3*k) begin n_fail++; $display("FAIL contend_timing: access %0d at cycle %0d want %0d", k, c, 2 + 3*k); end
        n_checks++; if ((port ? m1_rdata_o : m0_rdata_o) !== (port ? 32'h2424_2424 : 32'h2020_2020)) begin
          n_fail++; $display("FAIL contend_rdata: access %0d got %h", k, port ? m1_rdata_o : m0_rdata_o);
        end
        k++;
      end
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    n_checks++; if (k !== 6) begin n_fail++; $display("FAIL contend_timeout: completed %0d want 6", k); end
  endtask

  task automatic test_byte_enable;
    logic [31:0] rd;
    int          cyc;
    bit          ok;
    do_access(1'b1, 32'h30, 32'hAABB_CCDD, 4'h2, rd, cyc, ok);
    n_checks++; if (!ok || rd !== 32'h0) begin n_fail++; $display("FAIL be_write: ok=%0d old data got %h want 00000000", ok, rd); end
    do_access(1'b0, 32'h30, 32'h0, 4'h0, rd, cyc, ok);
    n_checks++; if (!ok || rd !== 32'h0000_CC00) begin n_fail++; $display("FAIL be_readback: ok=%0d got %h want 0000cc00", ok, rd); end
  endtask

  task automatic test_slow_ram;
    int vcnt, rcnt, r1cnt, rcyc;
    logic [31:0] rd;
    vcnt = 0; rcnt = 0; r1cnt = 0; rcyc = 0; rd = '0;
    @(negedge clk);
    ram_lat = 3;
    m0_valid = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h0; m0_we = 4'h0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (s_valid_o === 1'b1) vcnt++;
      if (m1_ready_o === 1'b1) r1cnt++;
      if (m0_ready_o === 1'b1) begin
        rcnt++; rcyc = c; rd = m0_rdata_o; m0_valid = 1'b0;
      end
    end
    ram_lat = 1;
    n_checks++; if (vcnt !== 1) begin n_fail++; $display("FAIL slow_s_valid_pulses: got %0d want 1", vcnt); end
    n_checks++; if (rcnt !== 1 || r1cnt !== 0) begin n_fail++; $display("FAIL slow_ready_count: m0=%0d m1=%0d want 1 0", rcnt, r1cnt); end
    n_checks++; if (rcyc !== 4) begin n_fail++; $display("FAIL slow_ready_cycle: got %0d want 4", rcyc); end
    n_checks++; if (rd !== 32'h55AA_55AA) begin n_fail++; $display("FAIL slow_rdata: got %h want 55aa55aa", rd); end
  endtask

  task automatic test_reset_in_wait;
    int rcnt, vcnt, cyc;
    logic [31:0] rd;
    bit ok;
    rcnt = 0; vcnt = 0;
    @(negedge clk);
    ram_lat = 4;
    m1_valid = 1'b1; m1_addr = 32'h44; m1_wdata = 32'hFFFF_0000; m1_we = 4'h0;
    @(negedge clk);
    n_checks++; if (s_valid_o !== 1'b1 || s_addr_o !== 32'h44) begin n_fail++; $display("FAIL rstwait_issue: v=%b addr=%h want 1 00000044", s_valid_o, s_addr_o); end
    @(negedge clk);
    rst = 1'b1; m1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (s_valid_o !== 1'b0 || s_addr_o !== 32'h0 || s_wdata_o !== 32'h0 || s_we_o !== 4'h0) begin
      n_fail++; $display("FAIL rstwait_outputs: v=%b addr=%h wdata=%h we=%h want all 0", s_valid_o, s_addr_o, s_wdata_o, s_we_o);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m0_ready_o === 1'b1 || m1_ready_o === 1'b1) rcnt++;
      if (s_valid_o === 1'b1) vcnt++;
    end
    ram_lat = 1;
    n_checks++; if (rcnt !== 0) begin n_fail++; $display("FAIL rstwait_stale_ready: got %0d pulses want 0", rcnt); end
    n_checks++; if (vcnt !== 0) begin n_fail++; $display("FAIL rstwait_spurious_grant: got %0d want 0", vcnt); end
    do_access(1'b1, 32'h44, 32'h0, 4'h0, rd, cyc, ok);
    n_checks++; if (!ok || rd !== 32'h1357_2468 || cyc !== 2) begin n_fail++; $display("FAIL rstwait_recover: ok=%0d data=%h cyc=%0d want 1 13572468 2", ok, rd, cyc); end
  endtask

  initial begin
    rst = 1'b1;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_we = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_we = '0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_contention();
    test_byte_enable();
    test_slow_ram();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
